// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter state encoding and default sizing used by
// both the controller and the TX arbiter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_IDLE
  } uart_arb_state_t;

  localparam int DEF_N_REQ     = 4;
  localparam int DEF_DATA_W    = 9;
  localparam int DEF_TIMEOUT_W = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority picker: the first set request found searching
// ptr+1, ptr+2, ... (mod N_REQ) wins.
module rr_arbiter #(
  parameter  int N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    int cand;
    // NOTE: every output gets a default before the search so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = 0;
    // Walk from farthest to nearest so the nearest requester is written last.
    for (int k = N_REQ; k >= 1; k--) begin
      cand = (int'(ptr) + k) % N_REQ;
      if (req[cand]) begin
        grant = N_REQ'(1) << cand;
        idx   = IDX_W'(cand);
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one direct-mode UART transmitter among N_REQ
// requesters, with a watchdog that aborts frames the transmitter never finishes.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int N_REQ     = DEF_N_REQ,
  parameter  int DATA_W    = DEF_DATA_W,
  parameter  int TIMEOUT_W = DEF_TIMEOUT_W,
  localparam int IDX_W     = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  input  logic                    tx_idle,
  input  logic                    tx_ready,
  output logic                    tx_start,
  output logic                    tx_valid,
  output logic [DATA_W-1:0]       tx_data,
  output logic [IDX_W-1:0]        grant_id,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    timeout
);

  // Last count before all-ones: the increment that reaches all-ones aborts.
  localparam logic [TIMEOUT_W-1:0] WD_EXPIRE = ~TIMEOUT_W'(1);

  uart_arb_state_t      state;
  logic [IDX_W-1:0]     ptr;
  logic [TIMEOUT_W-1:0] wdog;
  logic [N_REQ-1:0]     rr_grant;
  logic [IDX_W-1:0]     rr_idx;
  logic                 rr_any;
  logic                 offer;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (rr_grant),
    .idx   (rr_idx),
    .any   (rr_any)
  );

  assign offer     = (state == IDLE) && tx_idle;
  assign req_ready = offer ? rr_grant : '0;
  assign busy      = (state != IDLE);
  assign tx_valid  = tx_start;

  // NOTE: all state and registered outputs use non-blocking assignments so
  // every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= IDX_W'(N_REQ - 1);
      wdog       <= '0;
      tx_start   <= 1'b0;
      tx_data    <= '0;
      grant_id   <= '0;
      frame_done <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      timeout    <= 1'b0;
      case (state)
        IDLE: begin
          if (offer && rr_any) begin
            tx_data  <= req_data[rr_idx*DATA_W +: DATA_W];
            grant_id <= rr_idx;
            ptr      <= rr_idx;
            tx_start <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          if (tx_ready) begin
            tx_start <= 1'b0;
            wdog     <= '0;
            state    <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          wdog <= wdog + 1'b1;
          if (wdog == WD_EXPIRE) begin
            timeout <= 1'b1;
            state   <= IDLE;
          end else if (!tx_idle) begin
            state <= WAIT_IDLE;
          end
        end
        WAIT_IDLE: begin
          wdog <= wdog + 1'b1;
          // A completing frame beats a simultaneous watchdog expiry.
          if (tx_idle) begin
            frame_done <= 1'b1;
            state      <= IDLE;
          end else if (wdog == WD_EXPIRE) begin
            timeout <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized
// frames checked against a transaction-level round-robin/watchdog model.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int DW = 9;
  localparam int TW = 4;
  // Waiting cycles (after entering WAIT_BUSY) that may elapse before the abort.
  localparam int WD_LIMIT = (1 << TW) - 2;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            tx_idle;
  logic            tx_ready;
  logic            tx_start;
  logic            tx_valid;
  logic [DW-1:0]   tx_data;
  logic [1:0]      grant_id;
  logic            busy;
  logic            frame_done;
  logic            timeout;

  uart_tx_arbiter #(.N_REQ(N), .DATA_W(DW), .TIMEOUT_W(TW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .tx_idle    (tx_idle),
    .tx_ready   (tx_ready),
    .tx_start   (tx_start),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .grant_id   (grant_id),
    .busy       (busy),
    .frame_done (frame_done),
    .timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int last_win;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp_v, $time);
    end
  endtask

  // Round-robin rule: first valid requester after the previous winner.
  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++)
      if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  function automatic logic [N*DW-1:0] rand_data();
    logic [N*DW-1:0] d;
    for (int i = 0; i < N; i++) d[i*DW +: DW] = DW'($urandom);
    return d;
  endfunction

  // One frame: accept in current cycle, hold tx_ready low r START cycles,
  // then tx_idle stays high d cycles, low b cycles, then high again.
  task automatic run_frame(input logic [N-1:0] valid, input logic [N*DW-1:0] data,
                           input int r, input int d, input int b);
    int            win;
    logic [DW-1:0] exp_data;
    logic [N-1:0]  exp_ready;
    bit            done_ok;
    req_valid = valid;
    req_data  = data;
    tx_idle   = 1'b1;
    tx_ready  = 1'b0;
    #1;
    win       = rr_pick(valid, last_win);
    exp_data  = data[win*DW +: DW];
    exp_ready = N'(1) << win;
    check("accept_ready", req_ready, exp_ready);
    check("accept_busy", busy, 0);
    @(posedge clk); #1;
    req_valid = N'($urandom);
    req_data  = rand_data();
    for (int i = 0; i <= r; i++) begin
      tx_ready = (i == r);
      @(negedge clk);
      check("start_tx_start", tx_start, 1);
      check("start_tx_valid", tx_valid, 1);
      check("start_tx_data", tx_data, exp_data);
      check("start_grant_id", grant_id, win);
      check("start_ready_zero", req_ready, 0);
      @(posedge clk); #1;
    end
    tx_ready = 1'b0;
    done_ok  = (d + b <= WD_LIMIT);
    for (int k = 0; k <= WD_LIMIT; k++) begin
      tx_idle = (k < d) ? 1'b1 : (k < d + b) ? 1'b0 : 1'b1;
      @(negedge clk);
      check("wait_busy", busy, 1);
      check("wait_tx_start", tx_start, 0);
      check("wait_ready_zero", req_ready, 0);
      check("wait_no_pulse", {frame_done, timeout}, 0);
      if ((done_ok && k == d + b) || (!done_ok && k == WD_LIMIT)) begin
        @(posedge clk); @(negedge clk);
        check("end_frame_done", frame_done, done_ok);
        check("end_timeout", timeout, !done_ok);
        check("end_busy", busy, 0);
        last_win = win;
        return;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [N*DW-1:0] d;
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    tx_idle   = 1'b1;
    tx_ready  = 1'b0;
    last_win  = N - 1;
    #12;
    check("rst_busy", busy, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_pulses", {frame_done, timeout}, 0);
    check("rst_ready", req_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // All requesters continuously valid: strict rotation 0,1,2,3,0.
    for (int i = 0; i < 5; i++) begin
      run_frame(4'b1111, rand_data(), $urandom_range(0, 2), $urandom_range(0, 3),
                $urandom_range(1, 8));
      check("rotation_order", last_win, i % N);
    end

    // Single requester 2 with a known payload.
    d = rand_data();
    d[2*DW +: DW] = 9'h0A5;
    run_frame(4'b0100, d, 0, 2, 10);

    // Long stall in START: no watchdog activity, frame completes normally.
    run_frame(N'($urandom_range(1, 15)), rand_data(), 20, 1, 3);

    // Transmitter never goes busy: watchdog abort, then next requester wins.
    run_frame(4'b1111, rand_data(), 0, 30, 1);
    run_frame(4'b1111, rand_data(), 0, 0, 2);
    // Busy edge lands exactly on the last allowed cycle: done beats timeout.
    run_frame(4'b1111, rand_data(), 1, 4, WD_LIMIT - 4);

    // Transmitter not idle while IDLE: no grant.
    req_valid = 4'b1111;
    tx_idle   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("noidle_ready", req_ready, 0);
      check("noidle_busy", busy, 0);
      @(posedge clk); #1;
    end

    // Randomized frames.
    for (int i = 0; i < 25; i++)
      run_frame(N'($urandom_range(1, 15)), rand_data(), $urandom_range(0, 3),
                $urandom_range(0, 4), $urandom_range(1, 14));

    // Reset asserted in WAIT_IDLE.
    req_valid = 4'b0110;
    req_data  = rand_data();
    tx_idle   = 1'b1;
    tx_ready  = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    tx_ready = 1'b0;
    tx_idle  = 1'b0;
    @(posedge clk); #1;
    check("mid_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_tx_start", tx_start, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_tx_data", tx_data, 0);
    check("mid_rst_grant_id", grant_id, 0);
    check("mid_rst_pulses", {frame_done, timeout}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    last_win = N - 1;
    #1;
    check("mid_rst_no_pulse", {frame_done, timeout}, 0);
    run_frame(4'b1111, rand_data(), 0, 1, 2);
    check("mid_rst_first_grant", last_win, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
